// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 data-cache write-back path.
package cache_pkg;

  localparam int CACHE_LINE_W = 256;
  localparam int CACHE_ADDR_W = 32;
  localparam int LINE_OFFSET  = 5;

  typedef logic [CACHE_LINE_W-1:0]             line_t;
  typedef logic [CACHE_ADDR_W-LINE_OFFSET-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_tag_cam.sv
// DEPTH-way combinational tag compare against the valid write-buffer entries.
module wb_tag_cam
  import cache_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-LINE_OFFSET-1:0]            i_tag,
  input  logic [DEPTH-1:0][ADDR_W-LINE_OFFSET-1:0] i_entry_tags,
  input  logic [DEPTH-1:0]                         i_valid,
  output logic                                     o_hit,
  output logic [DEPTH-1:0]                         o_hit_onehot
);

  // At most one valid entry per tag, so the match vector is one-hot or zero.
  always_comb begin
    o_hit_onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit_onehot[i] = i_valid[i] && (i_entry_tags[i] == i_tag);
    end
  end

  assign o_hit = |o_hit_onehot;

endmodule

// File: rtl/dcache_write_buffer.sv
// Write-back buffer between the L1 D-cache and the memory arbiter D-port:
// absorbs evictions, drains them when idle, and serves reads that hit a buffered line.
module dcache_write_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] c_address,
  input  logic [LINE_W-1:0] c_line_i,
  output logic [LINE_W-1:0] c_line_o,
  input  logic              c_read,
  input  logic              c_write,
  output logic              c_resp,
  output logic [ADDR_W-1:0] m_address,
  output logic [LINE_W-1:0] m_line_o,
  input  logic [LINE_W-1:0] m_line_i,
  output logic              m_read,
  output logic              m_write,
  input  logic              m_resp,
  output logic              wb_empty,
  output logic              wb_full
);

  localparam int TAG_W = ADDR_W - LINE_OFFSET;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_state_e                    r_state;
  wb_state_e                    w_state_nxt;
  logic [DEPTH-1:0][TAG_W-1:0]  r_tag;
  logic [LINE_W-1:0]            r_line [DEPTH];
  logic [DEPTH-1:0]             r_valid;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  logic [CNT_W-1:0]             w_count_nxt;
  logic                         r_wb_empty;
  logic                         r_wb_full;
  logic [LINE_W-1:0]            r_c_line_o;

  logic [TAG_W-1:0]             w_req_tag;
  logic                         w_hit;
  logic [DEPTH-1:0]             w_hit_oh;
  logic [LINE_W-1:0]            w_hit_line;
  logic [DEPTH-1:0]             w_line_we;
  logic                         w_push;
  logic                         w_coalesce;
  logic                         w_pop;
  logic                         w_load_hit;
  logic                         w_load_mem;
  logic                         w_unused_offset;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_req_tag       = c_address[ADDR_W-1:LINE_OFFSET];
  assign w_unused_offset = ^c_address[LINE_OFFSET-1:0];

  wb_tag_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_cam (
    .i_tag        (w_req_tag),
    .i_entry_tags (r_tag),
    .i_valid      (r_valid),
    .o_hit        (w_hit),
    .o_hit_onehot (w_hit_oh)
  );

  always_comb begin
    w_hit_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_hit_oh[i]) w_hit_line = r_line[i];
    end
  end

  // A full buffer forces a drain first; the stalled write is retried from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_coalesce  = 1'b0;
    w_pop       = 1'b0;
    w_load_hit  = 1'b0;
    w_load_mem  = 1'b0;
    case (r_state)
      IDLE: begin
        if (c_write && w_hit) begin
          w_coalesce  = 1'b1;
          w_state_nxt = RESP;
        end else if (c_write && !r_wb_full) begin
          w_push      = 1'b1;
          w_state_nxt = RESP;
        end else if (c_write) begin
          w_state_nxt = DRAIN;
        end else if (c_read && w_hit) begin
          w_load_hit  = 1'b1;
          w_state_nxt = RESP;
        end else if (c_read) begin
          w_state_nxt = RD_MEM;
        end else if (!r_wb_empty) begin
          w_state_nxt = DRAIN;
        end
      end
      RD_MEM: begin
        if (m_resp) begin
          w_load_mem  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      DRAIN: begin
        if (m_resp) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_wb_empty <= 1'b1;
      r_wb_full  <= 1'b0;
      r_c_line_o <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_wb_empty <= (w_count_nxt == '0);
      r_wb_full  <= (w_count_nxt == CNT_W'(DEPTH));
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end
      if (w_load_hit) begin
        r_c_line_o <= w_hit_line;
      end else if (w_load_mem) begin
        r_c_line_o <= m_line_i;
      end
    end
  end

  // Entry storage carries no reset; validity lives in r_valid.
  always_comb begin
    w_line_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_line_we[i] = (w_coalesce && w_hit_oh[i]) ||
                     (w_push && (r_tail == PTR_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_line_we[i]) r_line[i] <= c_line_i;
      if (w_push && (r_tail == PTR_W'(i))) r_tag[i] <= w_req_tag;
    end
  end

  always_comb begin
    m_read    = 1'b0;
    m_write   = 1'b0;
    m_address = '0;
    m_line_o  = '0;
    case (r_state)
      RD_MEM: begin
        m_read    = 1'b1;
        m_address = {w_req_tag, {LINE_OFFSET{1'b0}}};
      end
      DRAIN: begin
        m_write   = 1'b1;
        m_address = {r_tag[r_head], {LINE_OFFSET{1'b0}}};
        m_line_o  = r_line[r_head];
      end
      default: ;
    endcase
  end

  assign c_resp   = (r_state == RESP);
  assign c_line_o = r_c_line_o;
  assign wb_empty = r_wb_empty;
  assign wb_full  = r_wb_full;

endmodule
